// File: rtl/load_store_unit.sv
// Data-memory access stage: req/ack handshake to dmem with
// store lane steering, load extension and ack timeout.
module load_store_unit #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  MemWrite,
  input  logic [2:0]  SizeLoad,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        bus_error,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {
    IDLE, WAIT, DONE, ERR
  } state_t;

  localparam logic [15:0] TMO = 16'(ACK_TIMEOUT - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  ld_q;
  logic [1:0]  off_q;
  logic [31:0] rdata_q;

  logic        is_st;
  logic        is_ld;
  logic        op_valid;
  logic [1:0]  sz;
  logic        aligned;
  logic [2:0]  ld_n;
  logic [3:0]  be_n;
  logic [31:0] wd_n;

  assign is_st = MemWrite != 2'b00;

  always_comb begin
    is_ld = 1'b0;
    case (SizeLoad)
      3'b001, 3'b010, 3'b011,
      3'b101, 3'b110: is_ld = 1'b1;
      default:        is_ld = 1'b0;
    endcase
  end

  assign op_valid = is_st | is_ld;
  // Store wins when both ops are presented.
  assign ld_n = is_st ? 3'b000 : SizeLoad;

  always_comb begin
    sz   = 2'd0;
    be_n = 4'b1111;
    wd_n = wdata;
    if (is_st) begin
      case (MemWrite)
        2'b01: begin
          sz   = 2'd0;
          be_n = 4'b0001 << addr[1:0];
          wd_n = {4{wdata[7:0]}};
        end
        2'b10: begin
          sz   = 2'd1;
          be_n = addr[1] ? 4'b1100 : 4'b0011;
          wd_n = {2{wdata[15:0]}};
        end
        default: begin
          sz   = 2'd2;
          be_n = 4'b1111;
          wd_n = wdata;
        end
      endcase
    end else begin
      case (SizeLoad[1:0])
        2'b01:   sz = 2'd0;
        2'b10:   sz = 2'd1;
        default: sz = 2'd2;
      endcase
    end
  end

  always_comb begin
    case (sz)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~addr[0];
      default: aligned = addr[1:0] == 2'b00;
    endcase
  end

  assign misaligned = (state == IDLE) & op_valid & ~aligned;
  assign stall = ((state == IDLE) & op_valid & aligned)
               | (state == WAIT);
  assign dmem_req   = state == WAIT;
  assign bus_error  = state == ERR;
  assign load_valid = (state == DONE) & (ld_q != 3'b000);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext;

  assign byte_v = rdata_q[{off_q, 3'b000} +: 8];
  assign half_v = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    case (ld_q)
      3'b001:  ext = {{24{byte_v[7]}}, byte_v};
      3'b010:  ext = {{16{half_v[15]}}, half_v};
      3'b011:  ext = rdata_q;
      3'b101:  ext = {24'h0, byte_v};
      3'b110:  ext = {16'h0, half_v};
      default: ext = 32'h0;
    endcase
  end

  assign load_data = load_valid ? ext : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      ld_q       <= '0;
      off_q      <= '0;
      rdata_q    <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (op_valid && aligned) begin
            state      <= WAIT;
            ld_q       <= ld_n;
            off_q      <= addr[1:0];
            dmem_we    <= is_st;
            dmem_addr  <= {addr[31:2], 2'b00};
            dmem_be    <= be_n;
            dmem_wdata <= is_st ? wd_n : 32'h0;
          end
        end
        WAIT: begin
          cnt <= cnt + 16'd1;
          if (dmem_ack) begin
            rdata_q <= dmem_rdata;
            state   <= DONE;
          end else if (cnt == TMO) begin
            state <= ERR;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        ERR: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a hand-driven
// memory ack and ACK_TIMEOUT=4.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  MemWrite = '0;
  logic [2:0]  SizeLoad = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misaligned;
  logic        bus_error;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;

  int errors = 0;
  int checks = 0;

  load_store_unit #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemWrite(MemWrite), .SizeLoad(SizeLoad),
    .addr(addr), .wdata(wdata),
    .stall(stall), .load_data(load_data),
    .load_valid(load_valid), .misaligned(misaligned),
    .bus_error(bus_error), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [1:0] mw,
                       input logic [2:0] sl,
                       input logic [31:0] a,
                       input logic [31:0] wd);
    @(negedge clk);
    MemWrite = mw;
    SizeLoad = sl;
    addr     = a;
    wdata    = wd;
    #1;
  endtask

  task automatic clear_ops();
    MemWrite = '0;
    SizeLoad = '0;
    addr     = '0;
    wdata    = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({stall, load_valid, misaligned, bus_error, dmem_req}
        !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b want 00000",
        {stall, load_valid, misaligned, bus_error, dmem_req});
    end
    checks++;
    if ({load_data, dmem_addr, dmem_wdata, dmem_be, dmem_we}
        !== '0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h %h %b want 0",
        load_data, dmem_addr, dmem_wdata, dmem_be, dmem_we);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sw();
    issue(2'b11, 3'b000, 32'h100, 32'hDEADBEEF);
    checks++;
    if (stall !== 1'b1 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL sw_idle stall=%b req=%b want 1 0",
        stall, dmem_req);
    end
    @(negedge clk);
    clear_ops();
    #1;
    checks++;
    if ({dmem_req, dmem_we, dmem_be, stall} !== 7'b1111111
        || dmem_addr !== 32'h100
        || dmem_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_wait got req=%b we=%b be=%b st=%b a=%h d=%h",
        dmem_req, dmem_we, dmem_be, stall, dmem_addr, dmem_wdata);
    end
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    checks++;
    if ({stall, dmem_req, load_valid, bus_error} !== 4'b0) begin
      errors++;
      $display("FAIL sw_done got %b want 0000",
        {stall, dmem_req, load_valid, bus_error});
    end
  endtask

  task automatic test_sb();
    issue(2'b01, 3'b000, 32'h103, 32'h000000A5);
    @(negedge clk);
    clear_ops();
    #1;
    checks++;
    if (dmem_be !== 4'b1000 || dmem_wdata !== 32'hA5A5A5A5
        || dmem_addr !== 32'h100 || dmem_we !== 1'b1) begin
      errors++;
      $display("FAIL sb got be=%b d=%h a=%h we=%b want 1000 a5a5a5a5 100 1",
        dmem_be, dmem_wdata, dmem_addr, dmem_we);
    end
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
  endtask

  task automatic test_loads();
    logic [2:0]  ops[6]  = '{3'b001, 3'b101, 3'b110,
                             3'b010, 3'b011, 3'b010};
    logic [31:0] as[6]   = '{32'h202, 32'h202, 32'h202,
                             32'h202, 32'h200, 32'h200};
    logic [31:0] rds[6]  = '{32'h12F03456, 32'h12F03456,
                             32'h12F03456, 32'h12F03456,
                             32'h12F03456, 32'h00008001};
    logic [31:0] exp[6]  = '{32'hFFFFFFF0, 32'h000000F0,
                             32'h000012F0, 32'h000012F0,
                             32'h12F03456, 32'hFFFF8001};
    for (int i = 0; i < 6; i++) begin
      issue(2'b00, ops[i], as[i], 32'h0);
      @(negedge clk);
      clear_ops();
      #1;
      checks++;
      if (dmem_we !== 1'b0 || dmem_be !== 4'b1111
          || dmem_addr !== 32'h200 || dmem_req !== 1'b1) begin
        errors++;
        $display("FAIL ld%0d_req we=%b be=%b a=%h req=%b",
          i, dmem_we, dmem_be, dmem_addr, dmem_req);
      end
      dmem_ack   = 1'b1;
      dmem_rdata = rds[i];
      @(negedge clk);
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      #1;
      checks++;
      if (load_valid !== 1'b1 || load_data !== exp[i]
          || stall !== 1'b0) begin
        errors++;
        $display("FAIL ld%0d_data got v=%b %h st=%b want 1 %h 0",
          i, load_valid, load_data, stall, exp[i]);
      end
      @(negedge clk);
      checks++;
      if (load_valid !== 1'b0 || load_data !== 32'h0) begin
        errors++;
        $display("FAIL ld%0d_after got v=%b %h want 0 0",
          i, load_valid, load_data);
      end
    end
  endtask

  task automatic test_misaligned();
    int reqs;
    issue(2'b00, 3'b011, 32'h102, 32'h0);
    checks++;
    if (misaligned !== 1'b1 || stall !== 1'b0
        || load_data !== 32'h0) begin
      errors++;
      $display("FAIL mis_lw got m=%b st=%b ld=%h want 1 0 0",
        misaligned, stall, load_data);
    end
    @(negedge clk);
    clear_ops();
    reqs = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (dmem_req) reqs++;
      @(negedge clk);
    end
    checks++;
    if (reqs !== 0 || misaligned !== 1'b0) begin
      errors++;
      $display("FAIL mis_noreq got reqs=%0d m=%b want 0 0",
        reqs, misaligned);
    end
    issue(2'b00, 3'b010, 32'h101, 32'h0);
    checks++;
    if (misaligned !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL mis_lh got m=%b st=%b want 1 0",
        misaligned, stall);
    end
    @(negedge clk);
    clear_ops();
    #1;
    checks++;
    if (dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL mis_lh_req got %b want 0", dmem_req);
    end
  endtask

  task automatic test_store_wins();
    issue(2'b01, 3'b011, 32'h101, 32'h0000003C);
    checks++;
    if (misaligned !== 1'b0 || stall !== 1'b1) begin
      errors++;
      $display("FAIL sw_win_idle got m=%b st=%b want 0 1",
        misaligned, stall);
    end
    @(negedge clk);
    clear_ops();
    #1;
    checks++;
    if (dmem_we !== 1'b1 || dmem_be !== 4'b0010
        || dmem_wdata !== 32'h3C3C3C3C) begin
      errors++;
      $display("FAIL sw_win got we=%b be=%b d=%h want 1 0010 3c3c3c3c",
        dmem_we, dmem_be, dmem_wdata);
    end
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    checks++;
    if (load_valid !== 1'b0) begin
      errors++;
      $display("FAIL sw_win_lv got %b want 0", load_valid);
    end
  endtask

  task automatic test_back_to_back();
    issue(2'b10, 3'b000, 32'h102, 32'h00001234);
    @(negedge clk);
    dmem_ack = 1'b1;
    MemWrite = 2'b00;
    @(negedge clk);
    dmem_ack = 1'b0;
    MemWrite = 2'b10;
    addr     = 32'h300;
    wdata    = 32'h0000BEEF;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done stall=%b want 0", stall);
    end
    @(negedge clk);
    #1;
    checks++;
    if (stall !== 1'b1 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle st=%b req=%b want 1 0",
        stall, dmem_req);
    end
    @(negedge clk);
    clear_ops();
    #1;
    checks++;
    if (dmem_be !== 4'b0011 || dmem_wdata !== 32'hBEEFBEEF
        || dmem_addr !== 32'h300 || dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL b2b_sh got be=%b d=%h a=%h req=%b",
        dmem_be, dmem_wdata, dmem_addr, dmem_req);
    end
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
  endtask

  task automatic test_timeout();
    int reqs;
    bit seen;
    issue(2'b11, 3'b000, 32'h400, 32'h11111111);
    reqs = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      clear_ops();
      #1;
      if (bus_error) begin
        seen = 1'b1;
        checks++;
        if (stall !== 1'b0 || dmem_req !== 1'b0
            || load_valid !== 1'b0) begin
          errors++;
          $display("FAIL tmo_err st=%b req=%b lv=%b want 0 0 0",
            stall, dmem_req, load_valid);
        end
      end else if (dmem_req) begin
        reqs++;
      end
    end
    checks++;
    if (!seen || reqs != 4) begin
      errors++;
      $display("FAIL tmo got seen=%b reqs=%0d want 1 4", seen, reqs);
    end
    @(negedge clk);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    #1;
    checks++;
    if (bus_error !== 1'b0 || stall !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL tmo_after be=%b st=%b req=%b want 0 0 0",
        bus_error, stall, dmem_req);
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    checks++;
    if (load_valid !== 1'b0 || load_data !== 32'h0) begin
      errors++;
      $display("FAIL late_ack lv=%b ld=%h want 0 0",
        load_valid, load_data);
    end
  endtask

  task automatic test_reset_in_wait();
    issue(2'b11, 3'b000, 32'h500, 32'h5555AAAA);
    @(negedge clk);
    clear_ops();
    #1;
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL rw_req got %b want 1", dmem_req);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL rw_async req=%b st=%b want 0 0",
        dmem_req, stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (dmem_req !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL rw_idle req=%b st=%b want 0 0", dmem_req, stall);
    end
    issue(2'b11, 3'b000, 32'h600, 32'h01234567);
    @(negedge clk);
    clear_ops();
    #1;
    checks++;
    if (dmem_req !== 1'b1 || dmem_addr !== 32'h600
        || dmem_wdata !== 32'h01234567) begin
      errors++;
      $display("FAIL rw_next req=%b a=%h d=%h",
        dmem_req, dmem_addr, dmem_wdata);
    end
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL rw_done st=%b req=%b want 0 0", stall, dmem_req);
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb();
    test_loads();
    test_misaligned();
    test_store_wins();
    test_back_to_back();
    test_timeout();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
